// File: rtl/mem_block_arbiter.sv
// Arbitrates one 256-bit block memory port between I-cache refills and D-cache refill/writeback.
// Optional `ARB_ROUND_ROBIN_EN` lets a pending I-cache read win right after a D-cache transfer.
module mem_block_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         i_req_read,
    input  logic [31:0]  i_addr,
    output logic [255:0] i_rblock,
    output logic         i_done,
    input  logic         d_req_read,
    input  logic         d_req_write,
    input  logic [31:0]  d_addr,
    input  logic [255:0] d_wblock,
    output logic [255:0] d_rblock,
    output logic         d_done,
    output logic [31:0]  mem_addr,
    output logic         mem_blk_read,
    output logic         mem_blk_write,
    output logic [255:0] mem_wblock,
    input  logic [255:0] mem_rblock,
    input  logic         mem_read_valid,
    input  logic         mem_write_valid,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic        in_xfer;
    logic        hit;
    logic        abort;
    logic        take_i_first;

`ifdef ARB_ROUND_ROBIN_EN
    logic        owner_d;
    logic        last_was_d;

    assign take_i_first = last_was_d & i_req_read;
`else
    assign take_i_first = 1'b0;
`endif

    assign in_xfer = (state == I_RD) || (state == D_RD) || (state == D_WR);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A matching valid always beats the watchdog, even on the last allowed cycle.
    always_comb begin
        next_state = state;
        hit        = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (take_i_first) begin
                    next_state = I_RD;
                end else if (d_req_write) begin
                    next_state = D_WR;
                end else if (d_req_read) begin
                    next_state = D_RD;
                end else if (i_req_read) begin
                    next_state = I_RD;
                end
            end
            I_RD, D_RD: hit = mem_read_valid;
            D_WR:       hit = mem_write_valid;
            DONE:       next_state = IDLE;
            default:    next_state = IDLE;
        endcase
        if (in_xfer) begin
            if (hit) begin
                next_state = DONE;
            end else if (wait_cnt == WAIT_LAST) begin
                abort      = 1'b1;
                next_state = DONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt      <= '0;
            mem_addr      <= '0;
            mem_wblock    <= '0;
            mem_blk_read  <= 1'b0;
            mem_blk_write <= 1'b0;
            busy          <= 1'b0;
            i_done        <= 1'b0;
            d_done        <= 1'b0;
            i_rblock      <= '0;
            d_rblock      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            wait_cnt      <= in_xfer ? wait_cnt + 16'd1 : 16'd0;
            mem_blk_read  <= (next_state == I_RD) || (next_state == D_RD);
            mem_blk_write <= (next_state == D_WR);
            busy          <= (next_state != IDLE);
            i_done        <= (next_state == DONE) && (state == I_RD);
            d_done        <= (next_state == DONE) && ((state == D_RD) || (state == D_WR));
            if ((state == IDLE) && (next_state != IDLE)) begin
                mem_addr   <= (next_state == I_RD) ? i_addr : d_addr;
                mem_wblock <= d_wblock;
            end
            // An aborted read returns an all-zero block rather than stale data.
            if ((state == I_RD) && (next_state == DONE)) begin
                i_rblock <= abort ? '0 : mem_rblock;
            end
            if ((state == D_RD) && (next_state == DONE)) begin
                d_rblock <= abort ? '0 : mem_rblock;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            owner_d    <= 1'b0;
            last_was_d <= 1'b0;
        end else begin
            if ((state == IDLE) && (next_state != IDLE)) begin
                owner_d <= (next_state != I_RD);
            end
            if (state == DONE) begin
                last_was_d <= owner_d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Scoreboard bench for mem_block_arbiter: stimulus pushes expected completions, a monitor pops them on done.
module tb_mem_block_arbiter;

    localparam int TMO = 8;

    logic         CLK;
    logic         RESET;
    logic         i_req_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rblock;
    logic         i_done;
    logic         d_req_read;
    logic         d_req_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wblock;
    logic [255:0] d_rblock;
    logic         d_done;
    logic [31:0]  mem_addr;
    logic         mem_blk_read;
    logic         mem_blk_write;
    logic [255:0] mem_wblock;
    logic [255:0] mem_rblock;
    logic         mem_read_valid;
    logic         mem_write_valid;
    logic         busy;
    logic         timeout_err;

    typedef struct {
        bit           is_d;
        bit           chk_data;
        logic [255:0] data;
    } exp_t;

    exp_t sb[$];
    int   assertions = 0;
    int   failures   = 0;

    mem_block_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .i_req_read(i_req_read),
        .i_addr(i_addr),
        .i_rblock(i_rblock),
        .i_done(i_done),
        .d_req_read(d_req_read),
        .d_req_write(d_req_write),
        .d_addr(d_addr),
        .d_wblock(d_wblock),
        .d_rblock(d_rblock),
        .d_done(d_done),
        .mem_addr(mem_addr),
        .mem_blk_read(mem_blk_read),
        .mem_blk_write(mem_blk_write),
        .mem_wblock(mem_wblock),
        .mem_rblock(mem_rblock),
        .mem_read_valid(mem_read_valid),
        .mem_write_valid(mem_write_valid),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Every done pulse must match the oldest outstanding expected completion.
    always @(negedge CLK) begin
        if (!RESET && (i_done || d_done)) begin
            exp_t e;
            checkOutput("single_done", {255'd0, i_done & d_done}, 256'd0);
            if (sb.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpected_done i_done=%0b d_done=%0b expected no pulse", i_done, d_done);
            end else begin
                e = sb.pop_front();
                checkOutput("done_owner_d", {255'd0, d_done}, {255'd0, e.is_d});
                if (e.chk_data) begin
                    checkOutput("rblock", e.is_d ? d_rblock : i_rblock, e.data);
                end
            end
        end
    end

    task automatic wait_strobe();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_blk_read || mem_blk_write) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("strobe_seen", {255'd0, ok}, 256'd1);
    endtask

    // One transfer; lat = strobe cycle carrying the valid, 0 = memory never answers.
    task automatic applyStimulus(input bit is_d, input bit is_wr, input logic [31:0] exp_addr,
                                 input int lat, input logic [255:0] data, input bit wrong_valid);
        exp_t e;
        int   n;
        e.is_d     = is_d;
        e.chk_data = !is_wr;
        e.data     = (lat == 0) ? 256'd0 : data;
        wait_strobe();
        sb.push_back(e);
        checkOutput("strobe_wr", {255'd0, mem_blk_write}, {255'd0, is_wr});
        checkOutput("strobe_rd", {255'd0, mem_blk_read}, {255'd0, !is_wr});
        checkOutput("mem_addr", {224'd0, mem_addr}, {224'd0, exp_addr});
        if (is_wr) begin
            checkOutput("mem_wblock", mem_wblock, data);
        end
        if (wrong_valid) begin
            if (is_wr) mem_read_valid = 1'b1;
            else       mem_write_valid = 1'b1;
        end
        if (lat == 0) begin
            n = 1;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (!(mem_blk_read || mem_blk_write)) break;
                n++;
            end
            checkOutput("strobe_cycles", 256'(n), 256'(TMO));
        end else begin
            for (int i = 1; i < lat; i++) begin
                tick();
                checkOutput("strobe_held", {255'd0, mem_blk_read | mem_blk_write}, 256'd1);
            end
            mem_read_valid  = 1'b0;
            mem_write_valid = 1'b0;
            if (is_wr) begin
                mem_write_valid = 1'b1;
            end else begin
                mem_read_valid = 1'b1;
                mem_rblock     = data;
            end
            tick();
        end
        mem_read_valid  = 1'b0;
        mem_write_valid = 1'b0;
        mem_rblock      = '0;
        checkOutput("done_cycle_busy", {255'd0, busy}, 256'd1);
        checkOutput("done_cycle_strobes", {254'd0, mem_blk_read, mem_blk_write}, 256'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=hung expected=finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        bit   exp_d[3];
        int   d_left;
        int   i_left;
        RESET = 1'b1;
        i_req_read = 0; i_addr = '0;
        d_req_read = 0; d_req_write = 0; d_addr = '0; d_wblock = '0;
        mem_rblock = '0; mem_read_valid = 0; mem_write_valid = 0;
        tick();
        tick();
        checkOutput("reset_busy", {255'd0, busy}, 256'd0);
        checkOutput("reset_strobes", {254'd0, mem_blk_read, mem_blk_write}, 256'd0);
        checkOutput("reset_mem_addr", {224'd0, mem_addr}, 256'd0);
        checkOutput("reset_wblock", mem_wblock, 256'd0);
        checkOutput("reset_rblocks", i_rblock | d_rblock, 256'd0);
        checkOutput("reset_flags", {253'd0, i_done, d_done, timeout_err}, 256'd0);
        RESET = 1'b0;
        tick();

        $display("[TB] I read alone");
        i_req_read = 1; i_addr = 32'h0040_0020;
        applyStimulus(0, 0, 32'h0040_0020, 4, {32{8'hA5}}, 0);
        i_req_read = 0;
        tick();
        checkOutput("idle_after_done", {255'd0, busy}, 256'd0);

        $display("[TB] priority with continuous requests");
`ifdef ARB_ROUND_ROBIN_EN
        exp_d[0] = 1; exp_d[1] = 0; exp_d[2] = 1;
`else
        exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 0;
`endif
        d_left = 2; i_left = 1;
        i_req_read = 1; i_addr = 32'h0040_1000;
        d_req_read = 1; d_addr = 32'h1000_2000;
        for (int g = 0; g < 3; g++) begin
            applyStimulus(exp_d[g], 0, exp_d[g] ? 32'h1000_2000 : 32'h0040_1000, 2,
                          {8{32'hD000_0000 + 32'(g)}}, 0);
            if (exp_d[g]) begin
                d_left--;
                if (d_left == 0) d_req_read = 0;
            end else begin
                i_left--;
                if (i_left == 0) i_req_read = 0;
            end
        end
        tick();

        $display("[TB] simultaneous D write and D read");
        d_req_write = 1; d_req_read = 1; d_addr = 32'h1000_0040;
        d_wblock = {4{64'h0123_4567_89AB_CDEF}};
        applyStimulus(1, 1, 32'h1000_0040, 3, {4{64'h0123_4567_89AB_CDEF}}, 1);
        d_req_write = 0;
        applyStimulus(1, 0, 32'h1000_0040, 1, {16{16'h5A3C}}, 1);
        d_req_read = 0;
        tick();

        $display("[TB] valid on last allowed cycle");
        i_req_read = 1; i_addr = 32'h0040_0100;
        applyStimulus(0, 0, 32'h0040_0100, TMO, {8{32'hCAFE_F00D}}, 0);
        i_req_read = 0;
        tick();
        checkOutput("no_timeout_at_boundary", {255'd0, timeout_err}, 256'd0);

        $display("[TB] stray valid in IDLE");
        mem_read_valid = 1; mem_write_valid = 1; mem_rblock = {32{8'hFF}};
        tick();
        tick();
        checkOutput("stray_busy", {255'd0, busy}, 256'd0);
        checkOutput("stray_strobes", {254'd0, mem_blk_read, mem_blk_write}, 256'd0);
        mem_read_valid = 0; mem_write_valid = 0; mem_rblock = '0;

        $display("[TB] timeout");
        d_req_read = 1; d_addr = 32'h1000_0080;
        applyStimulus(1, 0, 32'h1000_0080, 0, '0, 0);
        d_req_read = 0;
        checkOutput("timeout_err_set", {255'd0, timeout_err}, 256'd1);
        tick();
        tick();
        tick();
        checkOutput("timeout_err_sticky", {255'd0, timeout_err}, 256'd1);

        $display("[TB] reset mid-transfer");
        d_req_read = 1; d_addr = 32'h1000_00C0;
        wait_strobe();
        tick();
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("rst_strobes", {254'd0, mem_blk_read, mem_blk_write}, 256'd0);
        checkOutput("rst_busy_done", {253'd0, busy, i_done, d_done}, 256'd0);
        checkOutput("rst_timeout_err", {255'd0, timeout_err}, 256'd0);
        d_req_read = 0;
        tick();
        RESET = 1'b0;
        tick();
        i_req_read = 1; i_addr = 32'h0040_0200;
        applyStimulus(0, 0, 32'h0040_0200, 2, {8{32'h1357_9BDF}}, 0);
        i_req_read = 0;
        tick();
        tick();
        checkOutput("scoreboard_drained", 256'(sb.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
